// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a sequencer that zeroes every register.
// Build option: define ZERO_REG_PROTECT_EN to consume granted writes to register 0 without enabling the write.
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32  // must equal 2**ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] Data0,
  output logic              Gnt0,
  input  logic              Req1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] Data1,
  output logic              Gnt1,
  input  logic              Clear_Start,
  output logic              Clear_Busy,
  output logic              Clear_Done,
  output logic              Write_Reg,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data
);

`ifdef ZERO_REG_PROTECT_EN
  localparam bit ZeroProtect = 1'b1;
`else
  localparam bit ZeroProtect = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                last, last_nxt;
  logic                wr_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                arb_open;

  // Grants only while idle; a pending clear command or reset blocks the handshake.
  assign arb_open = (state == IDLE) && !Clear_Start && !Reset;

  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (arb_open) begin
      if (Req0 && (!Req1 || last)) Gnt0 = 1'b1;
      else if (Req1)               Gnt1 = 1'b1;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    wr_nxt    = 1'b0;
    addr_nxt  = W_Addr;
    data_nxt  = W_Data;
    unique case (state)
      IDLE: begin
        if (Clear_Start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (Gnt0) begin
          last_nxt = 1'b0;
          wr_nxt   = !(ZeroProtect && (Addr0 == '0));
          addr_nxt = Addr0;
          data_nxt = Data0;
        end else if (Gnt1) begin
          last_nxt = 1'b1;
          wr_nxt   = !(ZeroProtect && (Addr1 == '0));
          addr_nxt = Addr1;
          data_nxt = Data1;
        end
      end
      CLEAR: begin
        wr_nxt   = 1'b1;
        addr_nxt = cnt;
        data_nxt = '0;
        if (cnt == LastAddr) state_nxt = DONE;
        else                 cnt_nxt   = cnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    // NOTE: nonblocking assignments so every flop samples pre-edge values regardless of statement order.
    if (Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= 1'b1;
      Write_Reg  <= 1'b0;
      W_Addr     <= '0;
      W_Data     <= '0;
      Clear_Busy <= 1'b0;
      Clear_Done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last       <= last_nxt;
      Write_Reg  <= wr_nxt;
      W_Addr     <= addr_nxt;
      W_Data     <= data_nxt;
      Clear_Busy <= (state_nxt != IDLE);
      Clear_Done <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized traffic against a cycle-level model.
module tb_regfile_write_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int VW       = 5 + ADDR_W + DATA_W;
`ifdef ZERO_REG_PROTECT_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset, Req0, Req1, Clear_Start;
  logic [ADDR_W-1:0] Addr0, Addr1;
  logic [DATA_W-1:0] Data0, Data1;
  logic              Gnt0, Gnt1, Clear_Busy, Clear_Done, Write_Reg;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;

  regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Gnt0(Gnt0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Gnt1(Gnt1),
    .Clear_Start(Clear_Start), .Clear_Busy(Clear_Busy), .Clear_Done(Clear_Done),
    .Write_Reg(Write_Reg), .W_Addr(W_Addr), .W_Data(W_Data)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: m_pos is -1 when idle, k (0..NUM_REGS-1) in the k-th clearing cycle, NUM_REGS in the done cycle.
  int                m_last = 1;
  int                m_pos  = -1;
  logic              m_wr   = 1'b0;
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic              e_g0, e_g1;
  logic [DATA_W-1:0] m_rf [NUM_REGS];
  logic [DATA_W-1:0] d_rf [NUM_REGS];

  // Bench plays the register file: commit whatever the DUT presents at each edge.
  always @(posedge Clk) if (Write_Reg === 1'b1) d_rf[W_Addr] = W_Data;

  function automatic logic [VW-1:0] obs_vec();
    return {Gnt0, Gnt1, Clear_Busy, Clear_Done, Write_Reg, W_Addr, W_Data};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_g0, e_g1, (m_pos >= 0), (m_pos == NUM_REGS), m_wr, m_waddr, m_wdata};
  endfunction

  task automatic sample();
    @(negedge Clk);
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!Reset && m_pos < 0 && !Clear_Start) begin
      if (Req0 && Req1) begin
        if (m_last == 1) e_g0 = 1'b1;
        else             e_g1 = 1'b1;
      end else begin
        e_g0 = Req0;
        e_g1 = Req1;
      end
    end
  endtask

  task automatic advance();
    if (m_wr) m_rf[m_waddr] = m_wdata;
    if (Reset) begin
      m_pos = -1; m_last = 1; m_wr = 1'b0; m_waddr = '0; m_wdata = '0;
    end else if (m_pos >= 0) begin
      if (m_pos < NUM_REGS) begin
        m_wr = 1'b1; m_waddr = ADDR_W'(m_pos); m_wdata = '0; m_pos++;
      end else begin
        m_wr = 1'b0; m_pos = -1;
      end
    end else if (Clear_Start) begin
      m_pos = 0; m_wr = 1'b0;
    end else if (e_g0 || e_g1) begin
      m_last  = e_g0 ? 0 : 1;
      m_waddr = e_g0 ? Addr0 : Addr1;
      m_wdata = e_g0 ? Data0 : Data1;
      m_wr    = !(ZP && (m_waddr == '0));
    end else begin
      m_wr = 1'b0;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Clear_Start = 1'b0;
    Req0 = 1'b1; Addr0 = 5'd7; Data0 = 32'h1234_5678;
    Req1 = 1'b1; Addr1 = 5'd8; Data1 = 32'h8765_4321;
    sample(); advance();
    sample();
    total++;
    if (Gnt0 !== 1'b0 || Gnt1 !== 1'b0) begin
      bad++; $display("FAIL reset_gnt got=%b%b exp=00", Gnt0, Gnt1);
    end
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
    end
    advance();
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    sample();
    total++;
    if ({Write_Reg, W_Addr, W_Data, Clear_Busy, Clear_Done} !== '0) begin
      bad++; $display("FAIL reset_state got=%b/%h/%h/%b/%b exp=0", Write_Reg, W_Addr, W_Data, Clear_Busy, Clear_Done);
    end
    advance();
  endtask

  task automatic test_single();
    Req0 = 1'b1; Addr0 = 5'd5; Data0 = 32'hDEAD_BEEF;
    sample();
    total++;
    if (Gnt0 !== 1'b1 || Gnt1 !== 1'b0) begin
      bad++; $display("FAIL single_gnt got=%b%b exp=10", Gnt0, Gnt1);
    end
    advance();
    Req0 = 1'b0;
    sample();
    total++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd5 || W_Data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL single_write got=%b/%h/%h exp=1/05/deadbeef", Write_Reg, W_Addr, W_Data);
    end
    advance();
    sample();
    total++;
    if (Write_Reg !== 1'b0) begin
      bad++; $display("FAIL single_idle got=%b exp=0", Write_Reg);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] a0, a1;
    Reset = 1'b1;
    sample(); advance();
    Reset = 1'b0;
    a0 = ADDR_W'($urandom_range(1, 15));
    a1 = ADDR_W'($urandom_range(16, 31));
    Req0 = 1'b1; Addr0 = a0; Data0 = $urandom;
    Req1 = 1'b1; Addr1 = a1; Data1 = $urandom;
    for (int i = 0; i < 4; i++) begin
      sample();
      total++;
      if (Gnt0 !== (i % 2 == 0) || Gnt1 !== (i % 2 == 1)) begin
        bad++; $display("FAIL b2b_gnt%0d got=%b%b exp=%b%b", i, Gnt0, Gnt1, (i % 2 == 0), (i % 2 == 1));
      end
      if (i > 0) begin
        total++;
        if (Write_Reg !== 1'b1 || W_Addr !== ((i % 2 == 1) ? a0 : a1)) begin
          bad++; $display("FAIL b2b_addr%0d got=%b/%h exp=1/%h", i, Write_Reg, W_Addr, (i % 2 == 1) ? a0 : a1);
        end
      end
      advance();
    end
    Req0 = 1'b0; Req1 = 1'b0;
    sample();
    total++;
    if (Write_Reg !== 1'b1 || W_Addr !== a1 || W_Data !== Data1) begin
      bad++; $display("FAIL b2b_last got=%b/%h/%h exp=1/%h/%h", Write_Reg, W_Addr, W_Data, a1, Data1);
    end
    advance();
  endtask

  task automatic test_clear();
    int  no_gnt = 0, busy = 0, nxt = 0, done_n = 0, zero_bad = 0;
    bit  seq_ok = 1'b1, done_ok = 1'b0, got = 1'b0;
    Req0 = 1'b0;
    Req1 = 1'b1; Addr1 = 5'd9; Data1 = $urandom;
    Clear_Start = 1'b1;
    for (int i = 0; i < 60 && !got; i++) begin
      sample();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL clear_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (Gnt1 === 1'b1) got = 1'b1;
      else               no_gnt++;
      if (Clear_Busy === 1'b1) busy++;
      if (Clear_Busy === 1'b1 && Write_Reg === 1'b1) begin
        if (W_Addr !== ADDR_W'(nxt) || W_Data !== '0) seq_ok = 1'b0;
        nxt++;
      end
      if (Clear_Done === 1'b1) begin
        done_n++;
        if (Write_Reg === 1'b1 && W_Addr === ADDR_W'(NUM_REGS - 1) && W_Data === '0) done_ok = 1'b1;
      end
      advance();
      Clear_Start = 1'b0;
    end
    Req1 = 1'b0;
    total++;
    if (!got || no_gnt != NUM_REGS + 2) begin
      bad++; $display("FAIL clear_stall got=%0d exp=%0d granted=%b", no_gnt, NUM_REGS + 2, got);
    end
    total++;
    if (busy != NUM_REGS + 1) begin
      bad++; $display("FAIL clear_busy_len got=%0d exp=%0d", busy, NUM_REGS + 1);
    end
    total++;
    if (!seq_ok || nxt != NUM_REGS) begin
      bad++; $display("FAIL clear_addr_seq got=%0d ok=%b exp=%0d ok=1", nxt, seq_ok, NUM_REGS);
    end
    total++;
    if (done_n != 1 || !done_ok) begin
      bad++; $display("FAIL clear_done got=%0d ok=%b exp=1 ok=1", done_n, done_ok);
    end
    sample(); advance();
    for (int r = 0; r < NUM_REGS; r++) if (r != 9 && d_rf[r] !== '0) zero_bad++;
    total++;
    if (zero_bad != 0) begin
      bad++; $display("FAIL clear_zeroed got=%0d nonzero exp=0", zero_bad);
    end
  endtask

  task automatic test_clear_restart();
    int busy = 0, nxt = 0;
    bit seq_ok = 1'b1, seen = 1'b0;
    Clear_Start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      sample();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL restart_cycle cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (Clear_Busy === 1'b1) begin busy++; seen = 1'b1; end
      if (Clear_Busy === 1'b1 && Write_Reg === 1'b1) begin
        if (W_Addr !== ADDR_W'(nxt)) seq_ok = 1'b0;
        nxt++;
      end
      advance();
      Clear_Start = (m_pos == 10 || m_pos == NUM_REGS);
      if (seen && Clear_Busy !== 1'b1) break;
    end
    Clear_Start = 1'b0;
    total++;
    if (busy != NUM_REGS + 1 || !seq_ok || nxt != NUM_REGS) begin
      bad++; $display("FAIL restart_ignored got=%0d/%0d ok=%b exp=%0d/%0d ok=1", busy, nxt, seq_ok, NUM_REGS + 1, NUM_REGS);
    end
  endtask

  task automatic test_clear_reset();
    logic [DATA_W-1:0] d12, d20, d3;
    d12 = $urandom | 32'h1; d20 = $urandom | 32'h1; d3 = $urandom;
    Req0 = 1'b1; Addr0 = 5'd12; Data0 = d12;
    sample(); advance();
    Req0 = 1'b0; Req1 = 1'b1; Addr1 = 5'd20; Data1 = d20;
    sample(); advance();
    Req1 = 1'b0;
    sample(); advance();
    Clear_Start = 1'b1;
    for (int i = 0; i < 40 && m_pos != 12; i++) begin
      sample(); advance();
      Clear_Start = 1'b0;
    end
    Reset = 1'b1;
    sample();
    total++;
    if (obs_vec() !== exp_vec()) begin
      bad++; $display("FAIL abort_edge cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
    end
    advance();
    Reset = 1'b0;
    Req0 = 1'b1; Addr0 = 5'd3; Data0 = d3;
    sample();
    total++;
    if (Clear_Busy !== 1'b0 || Write_Reg !== 1'b0 || W_Addr !== '0 || Gnt0 !== 1'b1) begin
      bad++; $display("FAIL abort_state got=%b/%b/%h/%b exp=0/0/00/1", Clear_Busy, Write_Reg, W_Addr, Gnt0);
    end
    advance();
    Req0 = 1'b0;
    sample();
    total++;
    if (Write_Reg !== 1'b1 || W_Addr !== 5'd3 || W_Data !== d3) begin
      bad++; $display("FAIL abort_regrant got=%b/%h/%h exp=1/03/%h", Write_Reg, W_Addr, W_Data, d3);
    end
    advance();
    sample(); advance();
    total++;
    if (d_rf[12] !== d12 || d_rf[20] !== d20 || d_rf[11] !== '0 || d_rf[3] !== d3) begin
      bad++; $display("FAIL abort_regs got=%h/%h/%h/%h exp=%h/%h/0/%h", d_rf[12], d_rf[20], d_rf[11], d_rf[3], d12, d20, d3);
    end
  endtask

  task automatic test_zero_addr();
    Req0 = 1'b0; Req1 = 1'b1; Addr1 = '0; Data1 = 32'h1;
    sample();
    total++;
    if (Gnt1 !== 1'b1 || Gnt0 !== 1'b0) begin
      bad++; $display("FAIL zero_gnt got=%b%b exp=01", Gnt0, Gnt1);
    end
    advance();
    Req1 = 1'b0;
    sample();
    total++;
    if (Write_Reg !== !ZP || (!ZP && W_Addr !== '0)) begin
      bad++; $display("FAIL zero_write got=%b/%h exp=%b/00", Write_Reg, W_Addr, !ZP);
    end
    advance();
  endtask

  task automatic test_random();
    bit pend0 = 1'b0, pend1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!pend0 && $urandom_range(0, 2) == 0) begin
        pend0 = 1'b1; Addr0 = ADDR_W'($urandom); Data0 = $urandom;
      end
      if (!pend1 && $urandom_range(0, 2) == 0) begin
        pend1 = 1'b1; Addr1 = ADDR_W'($urandom); Data1 = $urandom;
      end
      Req0 = pend0; Req1 = pend1;
      Clear_Start = ($urandom_range(0, 59) == 0);
      Reset       = ($urandom_range(0, 249) == 0);
      sample();
      total++;
      if (obs_vec() !== exp_vec()) begin
        bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec());
      end
      if (e_g0) pend0 = 1'b0;
      if (e_g1) pend1 = 1'b0;
      advance();
    end
    Req0 = 1'b0; Req1 = 1'b0; Clear_Start = 1'b0; Reset = 1'b0;
    for (int i = 0; i < NUM_REGS + 4; i++) begin sample(); advance(); end
  endtask

  task automatic test_regfile();
    for (int r = 0; r < NUM_REGS; r++) begin
      total++;
      if (d_rf[r] !== m_rf[r]) begin
        bad++; $display("FAIL regfile[%0d] got=%h exp=%h", r, d_rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int r = 0; r < NUM_REGS; r++) begin
      m_rf[r] = 32'hA5A5_0000 | r;
      d_rf[r] = 32'hA5A5_0000 | r;
    end
    Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0; Clear_Start = 1'b0;
    Addr0 = '0; Addr1 = '0; Data0 = '0; Data1 = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_clear();
    test_clear_restart();
    test_clear_reset();
    test_zero_addr();
    test_random();
    test_regfile();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters (port 0, port 1) using round-robin arbitration.
- Also contains a clear sequencer: on command, it writes zero to every register, one address per cycle, as an alternative to reset-based clearing.
- All outputs are registered. They connect directly to the register file's Write_Reg, W_Addr and W_Data inputs.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NUM_REGS, 32, number of registers cleared by the sequencer; must equal 2**ADDR_W.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req0  in  1  port 0 write request.
- Addr0  in  ADDR_W  port 0 destination register.
- Data0  in  DATA_W  port 0 write data.
- Gnt0  out  1  port 0 accepted this cycle (combinational).
- Req1  in  1  port 1 write request.
- Addr1  in  ADDR_W  port 1 destination register.
- Data1  in  DATA_W  port 1 write data.
- Gnt1  out  1  port 1 accepted this cycle (combinational).
- Clear_Start  in  1  single-cycle command to start the clear sequence.
- Clear_Busy  out  1  clear sequence in progress.
- Clear_Done  out  1  one-cycle pulse at the end of the clear sequence.
- Write_Reg  out  1  register file write enable (registered).
- W_Addr  out  ADDR_W  register file write address (registered).
- W_Data  out  DATA_W  register file write data (registered).

Behaviour:
- Clock and reset:
  - One clock, Clk.
  - Reset is synchronous and active-high; Reset=1 at a rising edge forces the reset state.
- Reset state:
  - State=IDLE, Cnt=0, Last=1 (so port 0 wins the first contention).
  - Write_Reg=0, W_Addr=0, W_Data=0, Clear_Busy=0, Clear_Done=0.
- Handshake:
  - A request is consumed when Req and Gnt are both high at the same edge.
  - A requester holds Req, Addr and Data stable until it is granted.
  - Gnt is asserted only in IDLE, and never while Clear_Start=1.
- Arbitration (IDLE, Clear_Start=0):
  - Only one port requesting: that port is granted.
  - Both ports requesting: grant the port not equal to Last.
  - Last updates to the granted port on every grant.
  - At most one Gnt is high per cycle.
- Write output:
  - At the edge that consumes a grant, Write_Reg=1 and W_Addr/W_Data take the granted port's Addr/Data.
  - At an edge with no grant and no clear write, Write_Reg=0; W_Addr/W_Data hold their previous values.
  - Latency: the register file commits the write one edge after the grant edge.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: Clear_Start=1 moves to CLEAR with Cnt=0. In that cycle Clear_Start takes priority and both Gnt outputs are 0.
  - CLEAR: each edge loads Write_Reg=1, W_Addr=Cnt, W_Data=0, then increments Cnt. When Cnt==NUM_REGS-1, move to DONE.
  - DONE: lasts one cycle, then returns to IDLE with Write_Reg=0 at the exit edge.
- Clear timing:
  - Clear_Busy is high in CLEAR and DONE: exactly NUM_REGS+1 cycles.
  - Clear_Done is high only in DONE: one cycle, during which the write to address NUM_REGS-1 is presented.
  - Grants are possible again in the first IDLE cycle after DONE.
- Boundary conditions:
  - Clear_Start while in CLEAR or DONE is ignored (no restart, no extension).
  - Requests during a clear are stalled, not dropped.
  - Cnt does not wrap; the CLEAR to DONE transition occurs on the terminal count.
  - Reset mid-clear aborts immediately to the reset state at that edge. Registers not yet cleared keep their values.
  - Reset asserted in the same cycle as Req: no grant is consumed.

Optional Feature:
- Macro: ZERO_REG_PROTECT_EN.
- Defined:
  - A granted request with Addr==0 is still consumed (Gnt=1, Last updates).
  - It produces Write_Reg=0 at the following edge, so register 0 stays constant.
  - Clear sequence writes are unaffected.
- Not defined: writes to address 0 pass through like any other address.

Test Plan:
- Reset, then Req0=1, Addr0=5, Data0=0xDEADBEEF -> Gnt0=1 in the same cycle; next cycle Write_Reg=1, W_Addr=5, W_Data=0xDEADBEEF; the cycle after, Write_Reg=0.
- Req0 and Req1 held high for 4 cycles after reset -> grants go 0,1,0,1; W_Addr alternates Addr0/Addr1; never both Gnt high.
- Clear_Start pulse with Req1 held -> Gnt1=0 for 34 cycles. Clear_Busy=1 for 33 cycles; W_Addr steps 0..31 with W_Data=0. Clear_Done=1 with W_Addr=31. Gnt1=1 in the next cycle.
- Clear_Start re-pulsed at Cnt=10 -> sequence continues to 31 unchanged; Clear_Busy length is still 33.
- Reset asserted when Cnt=12 -> next cycle Clear_Busy=0, Write_Reg=0, W_Addr=0; a subsequent Req0 is granted normally.
- With ZERO_REG_PROTECT_EN, Req1=1, Addr1=0, Data1=0x1 -> Gnt1=1, next cycle Write_Reg=0. Without the macro -> Write_Reg=1, W_Addr=0.
